// File: rtl/layer_pkg.sv
// Shared definitions for the layer datapath blocks: result width, sizing
// helpers and the output-serializer state encoding.
package layer_pkg;

  typedef enum logic {IDLE, SEND} layer_state_t;

  function automatic int dw_of(input int feature_wide);
    return feature_wide + 16;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Beat counter width; a single-beat frame still gets one bit.
  function automatic int beat_bits(input int neu_num, input int lanes);
    int b;
    b = clog2(ceil_div(neu_num, lanes));
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/layer_beat_mux.sv
// Selects beat b of a packed result vector: LANES results per beat, lanes
// past the last neuron are zero with a cleared mask bit.
module layer_beat_mux
  import layer_pkg::*;
#(
  parameter int FEATURE_WIDE = 4,
  parameter int NEU_NUM      = 12,
  parameter int LANES        = 1
) (
  input  logic [NEU_NUM*dw_of(FEATURE_WIDE)-1:0] data,
  input  logic [beat_bits(NEU_NUM, LANES)-1:0]   beat,
  output logic [LANES*dw_of(FEATURE_WIDE)-1:0]   result,
  output logic [LANES-1:0]                       lane_mask
);

  localparam int DW  = dw_of(FEATURE_WIDE);
  localparam int BW  = beat_bits(NEU_NUM, LANES);
  localparam int ENT = 1 << BW;

  // Table sized to the full index range so unused codes read as padding.
  logic [ENT-1:0][LANES*DW-1:0] beat_data;
  logic [ENT-1:0][LANES-1:0]    beat_mask;

  for (genvar b = 0; b < ENT; b++) begin : g_beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int K = b * LANES + l;
      if (K < NEU_NUM) begin : g_live
        assign beat_data[b][l*DW +: DW] = data[K*DW +: DW];
        assign beat_mask[b][l]          = 1'b1;
      end else begin : g_pad
        assign beat_data[b][l*DW +: DW] = '0;
        assign beat_mask[b][l]          = 1'b0;
      end
    end
  end

  assign result    = beat_data[beat];
  assign lane_mask = beat_mask[beat];

endmodule

// File: rtl/layer_stream_out.sv
// Snapshots a layer's neuron results on a rising en and streams them out
// LANES per beat over valid/ready, with last, mask, busy, drop and done pulses.
//   state | meaning
//   IDLE  | waiting for a rising edge on en
//   SEND  | snapshot held, beats offered on out_valid until the last is accepted
module layer_stream_out
  import layer_pkg::*;
#(
  parameter int FEATURE_WIDE = 4,
  parameter int NEU_NUM      = 12,
  parameter int LANES        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic [NEU_NUM*dw_of(FEATURE_WIDE)-1:0] feature,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*dw_of(FEATURE_WIDE)-1:0]   result,
  output logic [LANES-1:0]                       lane_mask,
  output logic                                   out_last,
  output logic [beat_bits(NEU_NUM, LANES)-1:0]   beat_idx,
  output logic                                   busy,
  output logic                                   en_end,
  output logic                                   drop
);

  localparam int DW    = dw_of(FEATURE_WIDE);
  localparam int BW    = beat_bits(NEU_NUM, LANES);
  localparam int BEATS = ceil_div(NEU_NUM, LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  layer_state_t          state;
  logic                  en_r;
  logic                  rise;
  logic [NEU_NUM*DW-1:0] snap;
  logic [NEU_NUM*DW-1:0] mux_src;
  logic [BW-1:0]         mux_beat;
  logic [LANES*DW-1:0]   mux_result;
  logic [LANES-1:0]      mux_mask;

  assign rise = en & ~en_r;

  // At start the first beat comes straight from feature, so it can be
  // registered in the same edge that loads the snapshot.
  always_comb begin
    mux_src  = snap;
    mux_beat = beat_idx + BW'(1);
    if (state == IDLE) begin
      mux_src  = feature;
      mux_beat = '0;
    end
  end

  layer_beat_mux #(
    .FEATURE_WIDE(FEATURE_WIDE),
    .NEU_NUM     (NEU_NUM),
    .LANES       (LANES)
  ) u_beat_mux (
    .data     (mux_src),
    .beat     (mux_beat),
    .result   (mux_result),
    .lane_mask(mux_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_r      <= 1'b0;
      snap      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      lane_mask <= '0;
      out_last  <= 1'b0;
      beat_idx  <= '0;
      busy      <= 1'b0;
      en_end    <= 1'b0;
      drop      <= 1'b0;
    end else begin
      en_r   <= en;
      en_end <= 1'b0;
      drop   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= SEND;
            snap      <= feature;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            beat_idx  <= '0;
            result    <= mux_result;
            lane_mask <= mux_mask;
            out_last  <= (mux_beat == LAST_BEAT);
          end
        end
        SEND: begin
          if (rise) drop <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              result    <= '0;
              lane_mask <= '0;
              out_last  <= 1'b0;
              beat_idx  <= '0;
              en_end    <= 1'b1;
            end else begin
              beat_idx  <= mux_beat;
              result    <= mux_result;
              lane_mask <= mux_mask;
              out_last  <= (mux_beat == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
